// File: rtl/ddr_addr_pkg.sv
// Shared types and address helpers for the DDR burst address path.
//   burst_mode_e : INCR or WRAP burst
//   burst_req_t  : host request at the default widths (32-bit address, 4-bit length)
//   wrap_legal() : true when a WRAP burst length is one the address generator supports
//   wrap_next()  : next beat address inside a wrap boundary
package ddr_addr_pkg;

  typedef enum logic {
    BURST_INCR = 1'b0,
    BURST_WRAP = 1'b1
  } burst_mode_e;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_LEN_W  = 4;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_LEN_W-1:0]  len;
    burst_mode_e           mode;
  } burst_req_t;

  // Wrap is only meaningful for 2, 4, 8 or 16 beats (len = beats-1).
  function automatic logic wrap_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Bits above the boundary are kept; bits below it advance and roll over.
  // Arguments are zero-extended to 64 bits so any address width can share it.
  function automatic logic [63:0] wrap_next(input logic [63:0] addr,
                                            input logic [7:0]  len,
                                            input logic [63:0] beat_bytes);
    logic [63:0] mask;
    mask = (({56'd0, len} + 64'd1) * beat_bytes) - 64'd1;
    return (addr & ~mask) | ((addr + beat_bytes) & mask);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO with registered count.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all entries (push in the same cycle is discarded)
//   push, din  : write request; ignored when full
//   pop, dout  : read request; dout is the head entry (combinational read)
//   full, empty, count : occupancy, all derived from registered state
module req_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    count   = count_q;
    dout    = mem_q[rd_ptr_q];
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/addr_burst_queue.sv
// Queues burst requests and expands each into per-beat DDR column addresses.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop queued requests and the burst in progress
//   in_valid/in_ready   : request handshake; in_addr, in_len (beats-1), in_wrap
//   out_valid/out_ready : beat handshake; out_addr, out_last
//   busy                : queue non-empty or burst in progress
module addr_burst_queue
  import ddr_addr_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BEAT_BYTES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_wrap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    burst_mode_e       mode;
  } req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  burst_mode_e       mode_q, mode_d;

  req_t                  in_req, head;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  push, load, beat_done;
  logic [ADDR_W-1:0]     next_addr;

  // Wrap legality is resolved once at push so the pop side only sees a mode.
  always_comb begin
    in_req.addr = in_addr;
    in_req.len  = in_len;
    in_req.mode = (in_wrap && wrap_legal(8'(in_len))) ? BURST_WRAP : BURST_INCR;
    in_ready    = !fifo_full;
    push        = in_valid && !fifo_full && !flush;
  end

  req_fifo #(
    .T     (req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (in_req),
    .pop   (load),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    mode_d     = mode_q;

    out_valid = (state_q == BURST);
    out_addr  = addr_q;
    out_last  = out_valid && (beat_cnt_q == len_q);
    busy      = (fifo_count != '0) || (state_q == BURST);
    beat_done = out_valid && out_ready;

    if (mode_q == BURST_WRAP) begin
      next_addr = ADDR_W'(wrap_next(64'(addr_q), 8'(len_q), 64'(BEAT_BYTES)));
    end else begin
      next_addr = addr_q + ADDR_W'(BEAT_BYTES);
    end

    // Loading on the last accepted beat keeps back-to-back bursts gap-free.
    load = !flush && !fifo_empty && ((state_q == IDLE) || (beat_done && out_last));

    if (flush) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else if (load) begin
      state_d    = BURST;
      addr_d     = head.addr;
      len_d      = head.len;
      mode_d     = head.mode;
      beat_cnt_d = '0;
    end else if (beat_done) begin
      if (out_last) begin
        state_d = IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        addr_d     = next_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      mode_q     <= BURST_INCR;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      mode_q     <= mode_d;
    end
  end

endmodule

// File: tb/tb_addr_burst_queue.sv
module tb_addr_burst_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [3:0]  in_len = '0;
  logic        in_wrap = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic        out_last;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  addr_burst_queue #(
    .ADDR_W     (32),
    .LEN_W      (4),
    .DEPTH      (4),
    .BEAT_BYTES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_len    (in_len),
    .in_wrap   (in_wrap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] l, input logic w);
    in_valid = 1'b1;
    in_addr  = a;
    in_len   = l;
    in_wrap  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_beat(input logic [31:0] a, input logic last);
    exp_q.push_back({last, a});
  endtask

  task automatic drain(input string tag, input bit nogap);
    int unsigned wait_c;
    out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_c = 0;
      while (!out_valid && wait_c < 20) begin
        step();
        wait_c++;
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      if (nogap && i > 0) chk({tag, "_gap"}, 64'(wait_c), 64'd0);
      chk({tag, "_addr"}, 64'(out_addr), 64'(exp_q[i][31:0]));
      chk({tag, "_last"}, 64'(out_last), 64'(exp_q[i][32]));
      step();
    end
    exp_q.delete();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    // INCR with latency: queued after push edge, valid after the next edge
    push(32'h1000, 4'd3, 1'b0);
    chk("incr_lat_valid0", 64'(out_valid), 64'd0);
    chk("incr_lat_busy", 64'(busy), 64'd1);
    step();
    chk("incr_lat_valid1", 64'(out_valid), 64'd1);
    expect_beat(32'h1000, 1'b0);
    expect_beat(32'h1008, 1'b0);
    expect_beat(32'h1010, 1'b0);
    expect_beat(32'h1018, 1'b1);
    drain("incr", 1'b1);
    chk("incr_end_valid", 64'(out_valid), 64'd0);
    chk("incr_end_busy", 64'(busy), 64'd0);

    // WRAP, 8 beats, 64-byte boundary
    push(32'h2028, 4'd7, 1'b1);
    expect_beat(32'h2028, 1'b0);
    expect_beat(32'h2030, 1'b0);
    expect_beat(32'h2038, 1'b0);
    expect_beat(32'h2000, 1'b0);
    expect_beat(32'h2008, 1'b0);
    expect_beat(32'h2010, 1'b0);
    expect_beat(32'h2018, 1'b0);
    expect_beat(32'h2020, 1'b1);
    drain("wrap", 1'b1);

    // Fill: first request moves into the burst, four more fill the queue
    push(32'h3000, 4'd1, 1'b0);
    push(32'h3100, 4'd1, 1'b0);
    push(32'h3200, 4'd1, 1'b0);
    push(32'h3300, 4'd1, 1'b0);
    chk("full_ready_3q", 64'(in_ready), 64'd1);
    push(32'h3400, 4'd1, 1'b0);
    chk("full_ready_4q", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_addr  = 32'h3F00;
    in_len   = 4'd0;
    step();
    step();
    chk("full_held_ready", 64'(in_ready), 64'd0);
    chk("full_stall_addr", 64'(out_addr), 64'h3000);
    in_valid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      expect_beat(32'h3000 + 32'(b) * 32'h100, 1'b0);
      expect_beat(32'h3008 + 32'(b) * 32'h100, 1'b1);
    end
    drain("b2b", 1'b1);
    chk("b2b_end_valid", 64'(out_valid), 64'd0);
    chk("b2b_end_busy", 64'(busy), 64'd0);

    // Address overflow and stall stability
    push(32'hFFFF_FFF8, 4'd1, 1'b0);
    step();
    chk("ovf_addr0", 64'(out_addr), 64'hFFFF_FFF8);
    chk("ovf_last0", 64'(out_last), 64'd0);
    out_ready = 1'b1;
    step();
    chk("ovf_addr1", 64'(out_addr), 64'h0);
    chk("ovf_last1", 64'(out_last), 64'd1);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_addr", 64'(out_addr), 64'h0);
      chk("stall_last", 64'(out_last), 64'd1);
    end
    out_ready = 1'b1;
    step();
    chk("stall_done_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush on beat 2 with two entries queued and a push in the flush cycle
    push(32'h5000, 4'd7, 1'b0);
    push(32'h6000, 4'd0, 1'b0);
    push(32'h7000, 4'd0, 1'b0);
    chk("fl_beat0", 64'(out_addr), 64'h5000);
    out_ready = 1'b1;
    step();
    chk("fl_beat1", 64'(out_addr), 64'h5008);
    step();
    chk("fl_beat2", 64'(out_addr), 64'h5010);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 32'hA000;
    in_len   = 4'd0;
    in_wrap  = 1'b0;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    repeat (3) step();
    chk("fl_still_idle", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Reset mid-burst
    push(32'h8000, 4'd7, 1'b0);
    push(32'h9000, 4'd0, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    chk("mr_beat2", 64'(out_addr), 64'h8010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_addr", 64'(out_addr), 64'd0);
    chk("mr_last", 64'(out_last), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd1);

    // Illegal wrap length behaves as INCR; legal 2-beat wrap folds at 16 bytes
    push(32'h4010, 4'd2, 1'b1);
    push(32'h4008, 4'd1, 1'b1);
    expect_beat(32'h4010, 1'b0);
    expect_beat(32'h4018, 1'b0);
    expect_beat(32'h4020, 1'b1);
    expect_beat(32'h4008, 1'b0);
    expect_beat(32'h4000, 1'b1);
    drain("wlen", 1'b1);
    chk("wlen_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
